// File: rtl/fsm_cmd_responder_if.sv
// User-command interface between a command issuer (master) and the
// guarded command-consuming state machine (slave). Clock and reset are
// kept outside the interface as plain ports.
interface fsm_cmd_responder_if;

    // Command channel: issuer -> responder
    logic [2:0] user_input;
    logic       cmd_valid;
    logic       cmd_ready;

    // Response and status: responder -> issuer
    logic [2:0] out;
    logic       rsp_valid;
    logic       rsp_ok;
    logic [3:0] err_count;
    logic       locked;

    modport master (
        output user_input,
        output cmd_valid,
        input  cmd_ready,
        input  out,
        input  rsp_valid,
        input  rsp_ok,
        input  err_count,
        input  locked
    );

    modport slave (
        input  user_input,
        input  cmd_valid,
        output cmd_ready,
        output out,
        output rsp_valid,
        output rsp_ok,
        output err_count,
        output locked
    );

endinterface

// File: rtl/fsm_cmd_responder.sv
// Guarded command responder. Consumes 3-bit commands through a valid/ready
// handshake, moves only along legal state transitions, and routes illegal
// commands, corrupted state encodings and ACTIVE-phase timeouts to ERROR.
// Once enough errors have been seen since reset it latches into LOCKED and
// stops accepting commands until rst_n is asserted.
module fsm_cmd_responder #(
    parameter int TIMEOUT_CYCLES = 8,   // 2..255 cycles allowed in ACTIVE
    parameter int MAX_ERRORS     = 3    // 1..15 error entries before LOCKED
) (
    input  logic                clk,
    input  logic                rst_n,
    fsm_cmd_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4,
        ST_LOCKED = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_ARM   = 3'd1,
        CMD_START = 3'd2,
        CMD_STOP  = 3'd3,
        CMD_CLEAR = 3'd4
    } cmd_e;

    // Last ACTIVE cycle index before the timeout fires, and the error limit,
    // sized to the counters they are compared against.
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] ERR_LIMIT = 4'(MAX_ERRORS);

    // Error count saturates at its all-ones value instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // The state register is held as raw bits so the unreachable encodings
    // 6 and 7 stay representable and are detected rather than optimised away.
    logic [2:0] state_q;
    state_e     state_d;
    logic [3:0] err_cnt_q;
    logic [3:0] err_cnt_d;
    logic [7:0] tmo_cnt_q;
    logic [7:0] tmo_cnt_d;

    logic       cmd_ready;
    logic       accept;
    logic       cmd_legal;
    logic       tmo_hit;
    logic       to_error;

    logic       rsp_vld_p1;
    logic       rsp_ok_p1;

    assign cmd_ready = (state_q != ST_LOCKED);
    assign accept    = bus.cmd_valid && cmd_ready;
    assign tmo_hit   = (state_q == ST_ACTIVE) && (tmo_cnt_q == TMO_LAST);

    // Next-state, legality, error-entry and timeout-counter decisions.
    always_comb begin
        state_d   = state_e'(state_q);
        cmd_legal = 1'b1;
        to_error  = 1'b0;
        err_cnt_d = err_cnt_q;
        tmo_cnt_d = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.user_input)
                        CMD_NOP: state_d = ST_IDLE;
                        CMD_ARM: state_d = ST_ARMED;
                        default: cmd_legal = 1'b0;
                    endcase
                end
            end
            ST_ARMED: begin
                if (accept) begin
                    case (bus.user_input)
                        CMD_NOP:   state_d = ST_ARMED;
                        CMD_START: state_d = ST_ACTIVE;
                        CMD_CLEAR: state_d = ST_IDLE;
                        default:   cmd_legal = 1'b0;
                    endcase
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    case (bus.user_input)
                        CMD_NOP:  state_d = ST_ACTIVE;
                        CMD_STOP: state_d = ST_DONE;
                        default:  cmd_legal = 1'b0;
                    endcase
                end
                // An accepted STOP on the last allowed cycle still wins;
                // an illegal command on that cycle is counted only once.
                if (tmo_hit && (state_d == ST_ACTIVE)) begin
                    to_error = 1'b1;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    case (bus.user_input)
                        CMD_NOP:   state_d = ST_DONE;
                        CMD_CLEAR: state_d = ST_IDLE;
                        default:   cmd_legal = 1'b0;
                    endcase
                end
            end
            ST_ERROR: begin
                if (accept) begin
                    case (bus.user_input)
                        CMD_NOP:   state_d = ST_ERROR;
                        CMD_CLEAR: state_d = ST_IDLE;
                        default:   cmd_legal = 1'b0;
                    endcase
                end
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                // Corrupted encoding: recover through ERROR and refuse
                // to call any command accepted in this cycle legal.
                cmd_legal = 1'b0;
                to_error  = 1'b1;
            end
        endcase

        if (accept && !cmd_legal) begin
            to_error = 1'b1;
        end

        if (to_error) begin
            err_cnt_d = sat_inc4(err_cnt_q);
            state_d   = (err_cnt_d >= ERR_LIMIT) ? ST_LOCKED : ST_ERROR;
        end

        // Counter restarts on every entry into ACTIVE and counts cycles
        // spent there; it idles at zero everywhere else.
        if ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE)) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    // ---- stage p0 -> p1: state, counters and response are registered ----
    // State register, error/timeout counters and the one-cycle response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            err_cnt_q  <= 4'd0;
            tmo_cnt_q  <= 8'd0;
            rsp_vld_p1 <= 1'b0;
            rsp_ok_p1  <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_cnt_q  <= err_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rsp_vld_p1 <= accept;
            rsp_ok_p1  <= accept && cmd_legal;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.out       = state_q;
    assign bus.rsp_valid = rsp_vld_p1;
    assign bus.rsp_ok    = rsp_ok_p1;
    assign bus.err_count = err_cnt_q;
    assign bus.locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_fsm_cmd_responder.sv
// Bench for fsm_cmd_responder: directed scenarios followed by randomized
// command streams, all compared against a transition-table reference model.
module tb_fsm_cmd_responder;

    localparam int TMO  = 8;
    localparam int MAXE = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fsm_cmd_responder_if cmd_if ();

    fsm_cmd_responder #(
        .TIMEOUT_CYCLES (TMO),
        .MAX_ERRORS     (MAXE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cmd_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain integers, not the RTL encoding logic.
    int m_state;
    int m_err;
    int m_age;      // 1-based index of the current cycle spent in ACTIVE
    int m_rv;
    int m_ok;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Legal transition table: returns the target state, or -1 if illegal.
    function automatic int legal_next(input int s, input int c);
        if (s > 4) return -1;
        if (c == 0) return s;
        case (s)
            0:       return (c == 1) ? 1 : -1;
            1:       return (c == 2) ? 2 : ((c == 4) ? 0 : -1);
            2:       return (c == 3) ? 3 : -1;
            3, 4:    return (c == 4) ? 0 : -1;
            default: return -1;
        endcase
    endfunction

    task automatic model_step(input int v, input int c, input int rn);
        int  nxt;
        int  tgt;
        bit  err;
        bit  acc;
        bit  legal;
        if (rn == 0) begin
            m_state = 0; m_err = 0; m_age = 0; m_rv = 0; m_ok = 0;
            return;
        end
        acc   = (v != 0) && (m_state != 5);
        err   = 0;
        legal = 1;
        nxt   = m_state;
        if (m_state >= 6) begin
            err = 1; legal = 0;
        end else if (acc) begin
            tgt = legal_next(m_state, c);
            if (tgt < 0) begin err = 1; legal = 0; end
            else nxt = tgt;
        end
        if (!err && m_state == 2 && nxt == 2 && m_age == TMO) err = 1;
        if (err) begin
            if (m_err < 15) m_err++;
            nxt = (m_err >= MAXE) ? 5 : 4;
        end
        m_age   = (nxt == 2) ? ((m_state == 2) ? m_age + 1 : 1) : 0;
        m_state = nxt;
        m_rv    = acc;
        m_ok    = acc && legal;
    endtask

    // One clock: drive at negedge, step model at posedge, compare #1 later.
    task automatic cycle(input int v, input int c, input int rn);
        cmd_if.cmd_valid  = v[0];
        cmd_if.user_input = c[2:0];
        rst_n             = rn[0];
        @(posedge clk);
        model_step(v, c, rn);
        #1;
        chk("out",       cmd_if.out,       m_state);
        chk("err_count", cmd_if.err_count, m_err);
        chk("rsp_valid", cmd_if.rsp_valid, m_rv);
        if (m_rv != 0) chk("rsp_ok", cmd_if.rsp_ok, m_ok);
        chk("locked",    cmd_if.locked,    (m_state == 5) ? 1 : 0);
        chk("cmd_ready", cmd_if.cmd_ready, (m_state == 5) ? 0 : 1);
        @(negedge clk);
    endtask

    function automatic int pick_cmd(input int s);
        case (s)
            0:       return 1;
            1:       return ($urandom_range(0, 3) == 0) ? 4 : 2;
            2:       return ($urandom_range(0, 2) == 0) ? 3 : 0;
            3, 4:    return 4;
            default: return 0;
        endcase
    endfunction

    initial begin
        int seq_cmd [4];
        int seq_out [4];
        int n;
        int c;
        seq_cmd = '{1, 2, 3, 4};
        seq_out = '{1, 2, 3, 0};

        rst_n = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.user_input = 3'd0;
        @(negedge clk);

        // Reset state
        cycle(0, 0, 0);
        chk("rst_out", cmd_if.out, 0);
        chk("rst_ready", cmd_if.cmd_ready, 1);

        // Legal sequence ARM, START, STOP, CLEAR
        for (int i = 0; i < 4; i++) begin
            cycle(1, seq_cmd[i], 1);
            chk("seq_out", cmd_if.out, seq_out[i]);
            chk("seq_ok", cmd_if.rsp_ok, 1);
        end
        chk("seq_err", cmd_if.err_count, 0);

        // Illegal STOP from IDLE, then CLEAR
        cycle(1, 3, 1);
        chk("ill_out", cmd_if.out, 4);
        chk("ill_ok", cmd_if.rsp_ok, 0);
        chk("ill_err", cmd_if.err_count, 1);
        cycle(1, 4, 1);
        chk("clr_out", cmd_if.out, 0);
        chk("clr_ok", cmd_if.rsp_ok, 1);

        // Lockout after MAXE errors, then reset releases it
        cycle(0, 0, 0);
        for (int i = 0; i < MAXE; i++) begin
            cycle(1, 3, 1);
            if (i < MAXE - 1) cycle(1, 4, 1);
        end
        chk("lock_out", cmd_if.out, 5);
        chk("lock_flag", cmd_if.locked, 1);
        chk("lock_ready", cmd_if.cmd_ready, 0);
        chk("lock_err", cmd_if.err_count, MAXE);
        for (int i = 0; i < 5; i++) begin
            cycle(1, int'($urandom_range(0, 7)), 1);
            chk("lock_norsp", cmd_if.rsp_valid, 0);
        end
        cycle(0, 0, 0);
        chk("unlock_out", cmd_if.out, 0);
        chk("unlock_err", cmd_if.err_count, 0);

        // ACTIVE timeout with NOP/idle cycles
        cycle(1, 1, 1);
        cycle(1, 2, 1);
        n = 0;
        while (cmd_if.out != 3'd4 && n < 20) begin
            cycle(0, 0, 1);
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_err", cmd_if.err_count, 1);
        chk("tmo_norsp", cmd_if.rsp_valid, 0);

        // STOP on the last allowed ACTIVE cycle wins over the timeout
        cycle(0, 0, 0);
        cycle(1, 1, 1);
        cycle(1, 2, 1);
        for (int i = 0; i < TMO - 1; i++) cycle(1, 0, 1);
        cycle(1, 3, 1);
        chk("tmo_stop_out", cmd_if.out, 3);
        chk("tmo_stop_err", cmd_if.err_count, 0);

        // Illegal codes 5..7 in each reachable non-locked state
        for (int s = 0; s < 5; s++) begin
            for (int code = 5; code < 8; code++) begin
                cycle(0, 0, 0);
                case (s)
                    1: cycle(1, 1, 1);
                    2: begin cycle(1, 1, 1); cycle(1, 2, 1); end
                    3: begin cycle(1, 1, 1); cycle(1, 2, 1); cycle(1, 3, 1); end
                    4: cycle(1, 3, 1);
                    default: ;
                endcase
                cycle(1, code, 1);
                chk("code_out", cmd_if.out, 4);
                chk("code_ok", cmd_if.rsp_ok, 0);
            end
        end

        // Corrupted state register recovers through ERROR
        cycle(0, 0, 0);
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        m_state = 6;
        #1;
        chk("forced_out", cmd_if.out, 6);
        cycle(1, 1, 1);
        chk("unreach_out", cmd_if.out, 4);
        chk("unreach_ok", cmd_if.rsp_ok, 0);

        // Reset in ACTIVE discards a simultaneous STOP
        cycle(0, 0, 0);
        cycle(1, 1, 1);
        cycle(1, 2, 1);
        cycle(1, 3, 0);
        chk("rst_act_out", cmd_if.out, 0);
        chk("rst_act_rv", cmd_if.rsp_valid, 0);

        // Randomized command stream
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) c = int'($urandom_range(0, 7));
            else c = pick_cmd(m_state);
            cycle(($urandom_range(0, 9) < 8) ? 1 : 0, c,
                  ($urandom_range(0, 39) == 0) ? 0 : 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
